// File: rtl/axi_reg_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_reg_arbiter_if
// Description : AXI4-Lite bus bundle between the register arbiter (master)
//               and the audio register slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_reg_arbiter_if #(
    parameter int AXI_ADDR_WIDTH_P = 7,
    parameter int AXI_DATA_WIDTH_P = 32
) ();
    logic [AXI_ADDR_WIDTH_P-1:0]   awaddr;
    logic                          awvalid;
    logic                          awready;
    logic [AXI_DATA_WIDTH_P-1:0]   wdata;
    logic [AXI_DATA_WIDTH_P/8-1:0] wstrb;
    logic                          wvalid;
    logic                          wready;
    logic [1:0]                    bresp;
    logic                          bvalid;
    logic                          bready;
    logic [AXI_ADDR_WIDTH_P-1:0]   araddr;
    logic                          arvalid;
    logic                          arready;
    logic [AXI_DATA_WIDTH_P-1:0]   rdata;
    logic [1:0]                    rresp;
    logic                          rvalid;
    logic                          rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/axi_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_reg_arbiter
// Description : Two-requester arbiter running one AXI4-Lite transaction at a
//               time. Define ARB_ROUND_ROBIN_EN for round-robin arbitration;
//               otherwise requester 0 has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_reg_arbiter #(
    parameter int AXI_ADDR_WIDTH_P = 7,
    parameter int AXI_DATA_WIDTH_P = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    req_valid,
    output logic [1:0]                    req_ready,
    input  logic [1:0]                    req_write,
    input  logic [2*AXI_ADDR_WIDTH_P-1:0] req_addr,
    input  logic [2*AXI_DATA_WIDTH_P-1:0] req_wdata,
    output logic [1:0]                    rsp_valid,
    output logic [AXI_DATA_WIDTH_P-1:0]   rsp_rdata,
    output logic                          rsp_err,
    axi_reg_arbiter_if.master             axi
);

    localparam int         c_STRB_W = AXI_DATA_WIDTH_P / 8;
    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_WADDR  = 3'd1;
    localparam logic [2:0] c_WRESP  = 3'd2;
    localparam logic [2:0] c_RADDR  = 3'd3;
    localparam logic [2:0] c_RDATA  = 3'd4;
    localparam logic [2:0] c_DONE   = 3'd5;

    logic [2:0]                  r_state;
    logic [2:0]                  w_next_state;
    logic                        r_grant;
    logic                        w_win;
    logic                        w_accept;
    logic                        r_aw_done;
    logic                        r_w_done;
    logic                        r_err;
    logic                        w_aw_hs;
    logic                        w_w_hs;
    logic [AXI_ADDR_WIDTH_P-1:0] r_addr;
    logic [AXI_DATA_WIDTH_P-1:0] r_wdata;
    logic [AXI_DATA_WIDTH_P-1:0] r_rdata;

    // Accepting is gated by rst so no request is consumed during reset
    assign w_accept  = (r_state == c_IDLE) && (req_valid != 2'b00) && !rst;
    assign req_ready = w_accept ? (w_win ? 2'b10 : 2'b01) : 2'b00;
    assign w_aw_hs   = axi.awvalid && axi.awready;
    assign w_w_hs    = axi.wvalid && axi.wready;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_prio;

    always_comb begin
        w_win = ~req_valid[0];
        if (req_valid == 2'b11) begin
            w_win = r_prio;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (w_accept) begin
            r_prio <= ~w_win;
        end
    end
`else
    assign w_win = ~req_valid[0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_next_state = req_write[w_win] ? c_WADDR : c_RADDR;
                end
            end
            // AW and W complete independently, in either order
            c_WADDR: begin
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_next_state = c_WRESP;
                end
            end
            c_WRESP: if (axi.bvalid) w_next_state = c_DONE;
            c_RADDR: if (axi.arready) w_next_state = c_RDATA;
            c_RDATA: if (axi.rvalid) w_next_state = c_DONE;
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.wstrb   = '0;
        axi.bready  = 1'b0;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        axi.awaddr  = r_addr;
        axi.araddr  = r_addr;
        axi.wdata   = r_wdata;
        rsp_valid   = 2'b00;
        rsp_err     = 1'b0;
        rsp_rdata   = r_rdata;
        case (r_state)
            c_WADDR: begin
                axi.awvalid = !r_aw_done;
                axi.wvalid  = !r_w_done;
                axi.wstrb   = {c_STRB_W{1'b1}};
            end
            c_WRESP: axi.bready  = 1'b1;
            c_RADDR: axi.arvalid = 1'b1;
            c_RDATA: axi.rready  = 1'b1;
            c_DONE: begin
                rsp_valid = r_grant ? 2'b10 : 2'b01;
                rsp_err   = r_err;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_grant   <= w_win;
                        r_addr    <= w_win ? req_addr[2*AXI_ADDR_WIDTH_P-1:AXI_ADDR_WIDTH_P]
                                           : req_addr[AXI_ADDR_WIDTH_P-1:0];
                        r_wdata   <= w_win ? req_wdata[2*AXI_DATA_WIDTH_P-1:AXI_DATA_WIDTH_P]
                                           : req_wdata[AXI_DATA_WIDTH_P-1:0];
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end
                end
                c_WADDR: begin
                    if (w_aw_hs) r_aw_done <= 1'b1;
                    if (w_w_hs)  r_w_done  <= 1'b1;
                end
                c_WRESP: begin
                    if (axi.bvalid) begin
                        r_err   <= (axi.bresp != 2'b00);
                        r_rdata <= '0;
                    end
                end
                c_RDATA: begin
                    if (axi.rvalid) begin
                        r_err   <= (axi.rresp != 2'b00);
                        r_rdata <= axi.rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_reg_arbiter
// Description : Self-checking bench for axi_reg_arbiter with a register-file
//               AXI4-Lite slave and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_reg_arbiter;

    typedef struct {bit wr; logic [6:0] a; logic [31:0] d;} cmd_t;
    typedef struct {logic [1:0] vec; logic [31:0] rdata; logic err; int cyc;} rsp_t;
    typedef struct {logic [1:0] vec; int cyc;} gnt_t;
    typedef struct {logic [6:0] a; logic [31:0] d; logic [3:0] s; int cyc;} wlog_t;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v0 = 1'b0, v1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
    logic [6:0]  a0 = '0, a1 = '0;
    logic [31:0] d0 = '0, d1 = '0;
    logic [1:0]  req_valid, req_write, req_ready, rsp_valid;
    logic [13:0] req_addr;
    logic [63:0] req_wdata;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    int          cyc = 0;
    int          checks = 0, errors = 0;

    assign req_valid = {v1, v0};
    assign req_write = {wr1, wr0};
    assign req_addr  = {a1, a0};
    assign req_wdata = {d1, d0};

    axi_reg_arbiter_if #(.AXI_ADDR_WIDTH_P(7), .AXI_DATA_WIDTH_P(32)) axi ();

    axi_reg_arbiter #(.AXI_ADDR_WIDTH_P(7), .AXI_DATA_WIDTH_P(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .axi       (axi)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- register-file slave with programmable latencies -------
    int          aw_lat = 1, w_lat = 1, ar_lat = 1, b_lat = 0, r_lat = 0;
    logic [1:0]  slv_bresp = '0, slv_rresp = '0;
    bit          rd_ovr = 1'b0;
    logic [31:0] rd_ovr_data = '0;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    int          aw_hs_n = 0, w_hs_n = 0;
    bit          aw_got, w_got, b_arm, r_arm;
    logic [6:0]  aw_cap;
    logic [31:0] w_cap, r_hold;
    logic [3:0]  s_cap;
    logic [31:0] slv_mem [128];
    wlog_t       wr_log [$];

    always @(posedge clk) begin : slv
        logic        aw_now, w_now;
        logic [6:0]  wa;
        logic [31:0] wd, rv;
        logic [3:0]  ws;
        if (rst) begin
            axi.awready <= 1'b0; axi.wready <= 1'b0; axi.arready <= 1'b0;
            axi.bvalid  <= 1'b0; axi.rvalid <= 1'b0; axi.bresp   <= '0;
            axi.rresp   <= '0;   axi.rdata  <= '0;
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_arm <= 1'b0; r_arm <= 1'b0;
            for (int i = 0; i < 128; i++) slv_mem[i] <= '0;
        end else begin
            aw_now = axi.awvalid && axi.awready;
            w_now  = axi.wvalid && axi.wready;
            if (aw_now) begin axi.awready <= 1'b0; aw_cnt <= 0; end
            else if (axi.awvalid) begin
                if (aw_cnt + 1 >= aw_lat) axi.awready <= 1'b1;
                aw_cnt <= aw_cnt + 1;
            end
            if (w_now) begin axi.wready <= 1'b0; w_cnt <= 0; end
            else if (axi.wvalid) begin
                if (w_cnt + 1 >= w_lat) axi.wready <= 1'b1;
                w_cnt <= w_cnt + 1;
            end
            if (axi.arvalid && axi.arready) begin axi.arready <= 1'b0; ar_cnt <= 0; end
            else if (axi.arvalid) begin
                if (ar_cnt + 1 >= ar_lat) axi.arready <= 1'b1;
                ar_cnt <= ar_cnt + 1;
            end
            if (aw_now) begin aw_cap <= axi.awaddr; aw_hs_n <= aw_hs_n + 1; end
            if (w_now)  begin w_cap <= axi.wdata; s_cap <= axi.wstrb; w_hs_n <= w_hs_n + 1; end
            if ((aw_now || w_now) && (aw_got || aw_now) && (w_got || w_now)) begin
                wa = aw_now ? axi.awaddr : aw_cap;
                wd = w_now ? axi.wdata : w_cap;
                ws = w_now ? axi.wstrb : s_cap;
                slv_mem[wa] <= wd;
                wr_log.push_back('{wa, wd, ws, cyc});
                aw_got <= 1'b0; w_got <= 1'b0;
                if (b_lat == 0) begin axi.bvalid <= 1'b1; axi.bresp <= slv_bresp; end
                else begin b_arm <= 1'b1; b_cnt <= b_lat - 1; end
            end else begin
                if (aw_now) aw_got <= 1'b1;
                if (w_now)  w_got  <= 1'b1;
            end
            if (b_arm) begin
                if (b_cnt == 0) begin axi.bvalid <= 1'b1; axi.bresp <= slv_bresp; b_arm <= 1'b0; end
                else b_cnt <= b_cnt - 1;
            end
            if (axi.bvalid && axi.bready) begin axi.bvalid <= 1'b0; axi.bresp <= '0; end
            if (axi.arvalid && axi.arready) begin
                rv = rd_ovr ? rd_ovr_data : slv_mem[axi.araddr];
                if (r_lat == 0) begin axi.rvalid <= 1'b1; axi.rdata <= rv; axi.rresp <= slv_rresp; end
                else begin r_arm <= 1'b1; r_cnt <= r_lat - 1; r_hold <= rv; end
            end
            if (r_arm) begin
                if (r_cnt == 0) begin
                    axi.rvalid <= 1'b1; axi.rdata <= r_hold; axi.rresp <= slv_rresp; r_arm <= 1'b0;
                end else r_cnt <= r_cnt - 1;
            end
            if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
        end
    end

    // ---------------- requester drivers: hold until req_ready ---------------
    cmd_t q0 [$], q1 [$];

    initial begin : bfm0
        cmd_t c;
        bit   hs;
        forever begin
            @(posedge clk);
            hs = v0 && req_ready[0];
            #1;
            if (!v0 || hs) begin
                if (q0.size() > 0) begin c = q0.pop_front(); wr0 = c.wr; a0 = c.a; d0 = c.d; v0 = 1'b1; end
                else v0 = 1'b0;
            end
        end
    end

    initial begin : bfm1
        cmd_t c;
        bit   hs;
        forever begin
            @(posedge clk);
            hs = v1 && req_ready[1];
            #1;
            if (!v1 || hs) begin
                if (q1.size() > 0) begin c = q1.pop_front(); wr1 = c.wr; a1 = c.a; d1 = c.d; v1 = 1'b1; end
                else v1 = 1'b0;
            end
        end
    end

    // ---------------- grant / response capture ------------------------------
    gnt_t grant_q [$];
    rsp_t rsp_q [$];

    always @(negedge clk) begin
        if (!rst) begin
            if (req_ready != 2'b00) grant_q.push_back('{req_ready, cyc});
            if (rsp_valid != 2'b00) rsp_q.push_back('{rsp_valid, rsp_rdata, rsp_err, cyc});
        end
    end

    // ---------------- reference model and checks ----------------------------
    logic [31:0] mdl_mem [128];
    int          last_served = 1;
    cmd_t        c0q [$], c1q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {req_ready, rsp_valid, rsp_err, axi.awvalid, axi.wvalid,
                            axi.arvalid, axi.bready, axi.rready, axi.wstrb}, 64'd0);
        chk({tag, "_addr"}, {axi.awaddr, axi.araddr}, 64'd0);
        chk({tag, "_wdata"}, axi.wdata, 64'd0);
        chk({tag, "_rdata"}, rsp_rdata, 64'd0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 128; i++) mdl_mem[i] = '0;
        last_served = 1;
    endtask

    function automatic cmd_t rnd_cmd();
        cmd_t c;
        c.wr = 1'($urandom_range(0, 1));
        c.a  = 7'($urandom_range(0, 15));
        c.d  = $urandom;
        return c;
    endfunction

    // Predict grant order from the arbitration rule, launch both lists, then
    // compare every grant, response and slave-side write against the model.
    task automatic run_batch(input string tag, input bit timing);
        int   ord [$];
        int   i0 = 0, i1 = 0, n0 = c0q.size(), n1 = c1q.size(), t = 0, w;
        cmd_t c;
        gnt_t g;
        rsp_t r;
        wlog_t wl;
        logic [31:0] exp_rd;
        logic exp_err;
        while (i0 < n0 || i1 < n1) begin
            if (i0 < n0 && i1 < n1) w = RR_MODE ? 1 - last_served : 0;
            else w = (i0 < n0) ? 0 : 1;
            ord.push_back(w);
            last_served = w;
            if (w == 0) i0++; else i1++;
        end
        foreach (c0q[k]) q0.push_back(c0q[k]);
        foreach (c1q[k]) q1.push_back(c1q[k]);
        while (rsp_q.size() < n0 + n1 && t < 300 * (n0 + n1) + 100) begin
            @(posedge clk);
            t++;
        end
        repeat (8) @(posedge clk);
        chk({tag, "_rsp_count"}, rsp_q.size(), n0 + n1);
        foreach (ord[k]) begin
            w = ord[k];
            c = (w == 0) ? c0q.pop_front() : c1q.pop_front();
            exp_err = c.wr ? (slv_bresp != 2'b00) : (slv_rresp != 2'b00);
            exp_rd  = c.wr ? 32'd0 : (rd_ovr ? rd_ovr_data : mdl_mem[c.a]);
            if (c.wr) mdl_mem[c.a] = c.d;
            if (grant_q.size() > 0 && rsp_q.size() > 0) begin
                g = grant_q.pop_front();
                r = rsp_q.pop_front();
                chk($sformatf("%s_grant%0d", tag, k), g.vec, (w == 1) ? 2'b10 : 2'b01);
                chk($sformatf("%s_rsp_valid%0d", tag, k), r.vec, (w == 1) ? 2'b10 : 2'b01);
                chk($sformatf("%s_rdata%0d", tag, k), r.rdata, exp_rd);
                chk($sformatf("%s_err%0d", tag, k), r.err, exp_err);
                if (timing) chk($sformatf("%s_rsp_latency%0d", tag, k), r.cyc - g.cyc, 4);
                if (c.wr && wr_log.size() > 0) begin
                    wl = wr_log.pop_front();
                    chk($sformatf("%s_awaddr%0d", tag, k), wl.a, c.a);
                    chk($sformatf("%s_wdata%0d", tag, k), wl.d, c.d);
                    chk($sformatf("%s_wstrb%0d", tag, k), wl.s, 4'hF);
                    if (timing) chk($sformatf("%s_aw_latency%0d", tag, k), wl.cyc - g.cyc, 2);
                end
            end
        end
        chk({tag, "_extra_rsp"}, rsp_q.size(), 0);
        chk({tag, "_extra_wr"}, wr_log.size(), 0);
        grant_q.delete(); rsp_q.delete(); wr_log.delete();
        q0.delete(); q1.delete(); c0q.delete(); c1q.delete();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t, aw0, w0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset_hold");
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk_zero("reset_release");

        // Single write from requester 0 with an always-ready slave
        c0q.push_back('{1'b1, 7'h08, 32'h0000_0100});
        run_batch("wr_r0", 1'b1);

        // Single read from requester 1; slave returns 0xF
        rd_ovr = 1'b1; rd_ovr_data = 32'h0000_000F;
        c1q.push_back('{1'b0, 7'h20, 32'h0});
        run_batch("rd_r1", 1'b1);
        rd_ovr = 1'b0;

        // Both requesters continuously busy
        for (int k = 0; k < 4; k++) begin c0q.push_back(rnd_cmd()); c1q.push_back(rnd_cmd()); end
        run_batch("both", 1'b0);

        // W ready three cycles ahead of a slow AW ready
        aw_lat = 5; w_lat = 2; aw0 = aw_hs_n; w0 = w_hs_n;
        c0q.push_back('{1'b1, 7'h33, 32'hCAFE_0001});
        run_batch("split_aw_w", 1'b0);
        chk("split_aw_hs", aw_hs_n - aw0, 1);
        chk("split_w_hs", w_hs_n - w0, 1);
        aw_lat = 1; w_lat = 1;

        // Error responses on both channels
        slv_bresp = 2'b10; slv_rresp = 2'b11; rd_ovr = 1'b1; rd_ovr_data = 32'hA5A5_0001;
        c0q.push_back('{1'b1, 7'h05, 32'h1234_5678});
        c1q.push_back('{1'b0, 7'h06, 32'h0});
        run_batch("err", 1'b0);
        slv_bresp = 2'b00; slv_rresp = 2'b00; rd_ovr = 1'b0;

        // Reset while waiting for the write response
        b_lat = 20;
        q0.push_back('{1'b1, 7'h10, 32'h0000_0055});
        t = 0;
        @(negedge clk);
        while (!axi.bready && t < 50) begin @(negedge clk); t++; end
        chk("abort_in_wresp", axi.bready, 1'b1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk_zero("abort_reset");
        repeat (25) @(negedge clk);
        chk("abort_no_rsp", rsp_q.size(), 0);
        chk("abort_grants", grant_q.size(), 1);
        grant_q.delete(); rsp_q.delete(); wr_log.delete();
        model_reset();
        b_lat = 0;
        c0q.push_back('{1'b1, 7'h10, 32'h0000_0077});
        c1q.push_back('{1'b0, 7'h10, 32'h0});
        run_batch("after_abort", 1'b0);

        // Randomized rounds with random slave timing and response codes
        for (int rnd = 0; rnd < 4; rnd++) begin
            aw_lat = $urandom_range(1, 4); w_lat = $urandom_range(1, 4);
            ar_lat = $urandom_range(1, 4); b_lat = $urandom_range(0, 3);
            r_lat  = $urandom_range(0, 3);
            slv_bresp = 2'($urandom_range(0, 3)); slv_rresp = 2'($urandom_range(0, 3));
            for (int k = 0; k < int'($urandom_range(0, 4)); k++) c0q.push_back(rnd_cmd());
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) c1q.push_back(rnd_cmd());
            run_batch($sformatf("rand%0d", rnd), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
